// File: rtl/serial_deframer_pkg.sv
// Shared definitions for the serial deframer and its companion serializer/benches:
// receiver state encoding and frame-length helper.
package serial_deframer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam int WIDTH_DEFAULT     = 8;
  localparam int PARITY_EN_DEFAULT = 1;

  // Start + data + optional parity + stop.
  function automatic int frame_bits(input int width, input int parity_en);
    return width + 2 + parity_en;
  endfunction

  localparam int FRAME_BITS = frame_bits(WIDTH_DEFAULT, PARITY_EN_DEFAULT);

endpackage

// File: rtl/serial_in_shreg.sv
// Serial-in, parallel-out receive register: new bits enter at the MSB and
// move toward bit 0, so the first bit shifted in ends up in bit 0.
module serial_in_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic d_in;
    logic bit_reg;

    if (gi == WIDTH - 1) begin : g_msb
      assign d_in = din;
    end else begin : g_lower
      assign d_in = q[gi+1];
    end

    always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
        bit_reg <= 1'b0;
      end else if (shift_en) begin
        bit_reg <= d_in;
      end
    end

    assign q[gi] = bit_reg;
  end

endmodule

// File: rtl/serial_deframer.sv
// Receives start/stop-framed serial words (LSB first, optional even parity)
// and presents each good word with a one-cycle valid strobe and error flags.
module serial_deframer
  import serial_deframer_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int PARITY_EN = PARITY_EN_DEFAULT
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             din,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            par_acc_reg, par_acc_next;
  logic            rx_par_reg, rx_par_next;
  logic [WIDTH-1:0] out_data_reg, out_data_next;
  logic            out_valid_reg, out_valid_next;
  logic            parity_err_reg, parity_err_next;
  logic            frame_err_reg, frame_err_next;
  logic            shift_en;
  logic [WIDTH-1:0] word;

  serial_in_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clock    (clock),
    .clear    (clear),
    .shift_en (shift_en),
    .din      (din),
    .q        (word)
  );

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      par_acc_reg    <= 1'b0;
      rx_par_reg     <= 1'b0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      par_acc_reg    <= par_acc_next;
      rx_par_reg     <= rx_par_next;
      out_data_reg   <= out_data_next;
      out_valid_reg  <= out_valid_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    par_acc_next    = par_acc_reg;
    rx_par_next     = rx_par_reg;
    out_data_next   = out_data_reg;
    out_valid_next  = 1'b0;
    parity_err_next = parity_err_reg;
    frame_err_next  = 1'b0;
    shift_en        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!din) begin
          state_next   = DATA;
          cnt_next     = '0;
          par_acc_next = 1'b0;
        end
      end
      DATA: begin
        shift_en     = 1'b1;
        par_acc_next = par_acc_reg ^ din;
        if (cnt_reg == LAST_BIT) begin
          state_next = (PARITY_EN != 0) ? PARITY : STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PARITY: begin
        rx_par_next = din;
        state_next  = STOP;
      end
      STOP: begin
        // A low stop bit only flags the error; it is never taken as a new start.
        state_next = IDLE;
        if (din) begin
          out_data_next   = word;
          out_valid_next  = 1'b1;
          parity_err_next = (PARITY_EN != 0) ? (par_acc_reg ^ rx_par_reg) : 1'b0;
        end else begin
          frame_err_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_data   = out_data_reg;
  assign out_valid  = out_valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_deframer.sv
// Self-checking bench for serial_deframer: WIDTH=8/parity and WIDTH=4/no-parity
// instances checked every cycle against a stream-parsing reference model.
module tb_serial_deframer;
  import serial_deframer_pkg::*;

  logic       clk = 1'b0;
  logic       clear;
  logic       din8, din4;
  logic [7:0] out_data8;
  logic [3:0] out_data4;
  logic       out_valid8, parity_err8, frame_err8, busy8;
  logic       out_valid4, parity_err4, frame_err4, busy4;

  int checks = 0;
  int errors = 0;
  int cur_dut = 0;

  bit          stream[$];
  logic [15:0] held_data[2];
  logic        held_perr[2];

  always #5 clk = ~clk;

  serial_deframer #(.WIDTH(8), .PARITY_EN(1)) u8 (
    .clock(clk), .clear(clear), .din(din8), .out_data(out_data8),
    .out_valid(out_valid8), .parity_err(parity_err8), .frame_err(frame_err8), .busy(busy8)
  );

  serial_deframer #(.WIDTH(4), .PARITY_EN(0)) u4 (
    .clock(clk), .clear(clear), .din(din4), .out_data(out_data4),
    .out_valid(out_valid4), .parity_err(parity_err4), .frame_err(frame_err4), .busy(busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d step %0d: got %0h expected %0h", tag, cur_dut, idx, obs, exp);
    end
  endtask

  task automatic add_frame(input int w, input int p, input int data, input bit pbit,
                           input bit stop, input int gap);
    stream.push_back(1'b0);
    for (int j = 0; j < w; j++) stream.push_back(data[j]);
    if (p != 0) stream.push_back(pbit);
    stream.push_back(stop);
    repeat (gap) stream.push_back(1'b1);
  endtask

  // Model: scan the bit list for frames, then drive it cycle by cycle and compare.
  task automatic play(input int sel);
    int          w, p, s, n, i, ones;
    logic [15:0] wv, hd;
    logic        hp, pbit;
    bit          e_valid[], e_ferr[], e_busy[], e_perr[];
    logic [15:0] e_word[];
    logic [15:0] o_data;
    logic        o_valid, o_ferr, o_perr, o_busy;

    cur_dut = (sel == 0) ? 8 : 4;
    w = (sel == 0) ? 8 : 4;
    p = (sel == 0) ? 1 : 0;
    s = frame_bits(w, p) - 1;
    n = stream.size();
    e_valid = new[n]; e_ferr = new[n]; e_busy = new[n]; e_perr = new[n]; e_word = new[n];

    i = 0;
    while (i < n) begin
      if (stream[i] == 1'b0 && i + s < n) begin
        wv = '0;
        ones = 0;
        for (int j = 0; j < w; j++) begin
          if (stream[i+1+j]) begin
            wv[j] = 1'b1;
            ones++;
          end
        end
        for (int k = i; k < i + s; k++) e_busy[k] = 1'b1;
        pbit = (p != 0) ? stream[i+w+1] : 1'b0;
        if (stream[i+s]) begin
          e_valid[i+s] = 1'b1;
          e_word[i+s]  = wv;
          e_perr[i+s]  = (p != 0) && (((ones % 2) == 1) != pbit);
        end else begin
          e_ferr[i+s] = 1'b1;
        end
        i += s + 1;
      end else begin
        i++;
      end
    end

    hd = held_data[sel];
    hp = held_perr[sel];
    for (int k = 0; k < n; k++) begin
      if (sel == 0) din8 = stream[k];
      else          din4 = stream[k];
      tick();
      if (e_valid[k]) begin
        hd = e_word[k];
        hp = e_perr[k];
      end
      if (sel == 0) begin
        o_data = {8'h00, out_data8}; o_valid = out_valid8; o_ferr = frame_err8;
        o_perr = parity_err8; o_busy = busy8;
      end else begin
        o_data = {12'h000, out_data4}; o_valid = out_valid4; o_ferr = frame_err4;
        o_perr = parity_err4; o_busy = busy4;
      end
      check("out_valid", k, o_valid, e_valid[k]);
      check("frame_err", k, o_ferr, e_ferr[k]);
      check("busy", k, o_busy, e_busy[k]);
      check("out_data", k, o_data, hd);
      check("parity_err", k, o_perr, hp);
    end
    din8 = 1'b1;
    din4 = 1'b1;
    held_data[sel] = hd;
    held_perr[sel] = hp;
    stream.delete();
  endtask

  task automatic check_all_zero(input string tag);
    cur_dut = 0;
    check({tag, "_data8"}, 0, {8'h00, out_data8}, 16'h0);
    check({tag, "_valid8"}, 0, out_valid8, 16'h0);
    check({tag, "_perr8"}, 0, parity_err8, 16'h0);
    check({tag, "_ferr8"}, 0, frame_err8, 16'h0);
    check({tag, "_busy8"}, 0, busy8, 16'h0);
    check({tag, "_data4"}, 0, {12'h000, out_data4}, 16'h0);
    check({tag, "_busy4"}, 0, busy4, 16'h0);
  endtask

  initial begin
    int d;
    bit pb, st;
    logic [7:0] abort_word;

    clear = 1'b0;
    din8  = 1'b1;
    din4  = 1'b1;
    held_data[0] = '0; held_data[1] = '0;
    held_perr[0] = 1'b0; held_perr[1] = 1'b0;
    repeat (2) tick();
    check_all_zero("reset");
    clear = 1'b1;
    tick();

    // 0xA5 with correct then wrong parity, then a bad-stop frame.
    stream.push_back(1'b1);
    add_frame(8, 1, 8'hA5, 1'b0, 1'b1, 2);
    add_frame(8, 1, 8'hA5, 1'b1, 1'b1, 2);
    add_frame(8, 1, 8'h3C, 1'b0, 1'b0, 2);
    play(0);

    // Back-to-back frames with no idle gap.
    add_frame(8, 1, 8'h3C, 1'b0, 1'b1, 0);
    add_frame(8, 1, 8'hC3, 1'b0, 1'b1, 2);
    play(0);

    // Abort a frame after 4 data bits with an asynchronous clear.
    abort_word = 8'h5A;
    cur_dut = 8;
    din8 = 1'b0;
    tick();
    for (int j = 0; j < 4; j++) begin
      din8 = abort_word[j];
      tick();
    end
    check("busy_midframe", 0, busy8, 16'h1);
    din8 = 1'b1;
    clear = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge clk);
    #1;
    clear = 1'b1;
    held_data[0] = '0; held_data[1] = '0;
    held_perr[0] = 1'b0; held_perr[1] = 1'b0;
    add_frame(8, 1, 8'h81, 1'b0, 1'b1, 2);
    play(0);

    // 4-bit stream 0,1,0,1,1,1 -> word 0xD, no parity.
    stream.push_back(1'b0); stream.push_back(1'b1); stream.push_back(1'b0);
    stream.push_back(1'b1); stream.push_back(1'b1); stream.push_back(1'b1);
    stream.push_back(1'b1); stream.push_back(1'b1);
    play(1);

    // Random frames: occasional bad parity and bad stop, gaps 0..2.
    for (int r = 0; r < 30; r++) begin
      d  = int'($urandom_range(0, 255));
      pb = (^d[7:0]) ^ ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 7) != 0);
      add_frame(8, 1, d, pb, st, int'($urandom_range(0, 2)));
    end
    stream.push_back(1'b1);
    play(0);

    for (int r = 0; r < 30; r++) begin
      d  = int'($urandom_range(0, 15));
      st = ($urandom_range(0, 7) != 0);
      add_frame(4, 0, d, 1'b0, st, int'($urandom_range(0, 2)));
    end
    stream.push_back(1'b1);
    play(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_deframer.md
# serial_deframer

Downstream consumer of the serial shift-register chain: samples one serial bit per clock and recognises start/stop-framed words. Each word is WIDTH data bits, LSB first, with optional even parity. Completed words are presented as a parallel word with a one-cycle valid strobe and error flags. It turns the bit stream shifted out of the shift chain back into words for the next stage.

## Interface
- WIDTH, 8, data bits per frame (2..16)
- PARITY_EN, 1, 1 = frame carries an even-parity bit after the data; 0 = no parity bit
- clock  input  1  sampling clock; all state changes on posedge
- clear  input  1  asynchronous, active-low reset
- din  input  1  serial bit stream, one bit per clock; idle level 1
- out_data  output  WIDTH  last completed word; holds until the next completed frame
- out_valid  output  1  one-cycle strobe: out_data updated with a good-stop frame
- parity_err  output  1  qualified by out_valid; 1 = received parity bit mismatched
- frame_err  output  1  one-cycle strobe: stop bit sampled as 0; frame discarded
- busy  output  1  1 while a frame is being received (state != IDLE)

## Operation
- Frame format on din: start bit 0, WIDTH data bits LSB first, parity bit if PARITY_EN, stop bit 1.
- State machine:
  - IDLE: on din==0 -> DATA, bit counter := 0. Otherwise stay.
  - DATA: shift din into shift_reg at the MSB end, shifting right, so the first data bit ends at bit 0. Accumulate running XOR. The counter increments; on the WIDTH-th data bit -> PARITY if PARITY_EN, else STOP.
  - PARITY: latch din as the received parity bit -> STOP.
  - STOP, din==1: out_data := assembled word, out_valid := 1, parity_err := (XOR of data bits) != received parity bit (0 when PARITY_EN=0) -> IDLE.
  - STOP, din==0: frame_err := 1, out_data unchanged, out_valid stays 0 -> IDLE. This 0 is not reinterpreted as a start bit.
- Bit counter is $clog2(WIDTH) bits wide and never wraps inside a frame. It is reset to 0 on every start.
- The data shift register is internal; out_data changes only on a good stop bit.
- Reset (clear==0) at any time, including mid-frame: state := IDLE, counter, shift register and parity accumulator := 0; partial frame is lost.
- Reset values: out_data=0, out_valid=0, parity_err=0, frame_err=0, busy=0.

## Timing
- Label edge 0 as the edge that samples the start bit.
- Data bits are sampled at edges 1..WIDTH.
- The parity bit is sampled at edge WIDTH+1 when PARITY_EN=1.
- The stop bit is sampled at edge S = WIDTH+1+PARITY_EN.
- out_valid (or frame_err) is high in the cycle after edge S, exactly one cycle. Latency from start sample to strobe is S cycles (10 for WIDTH=8, PARITY_EN=1).
- busy is high from after edge 0 until after edge S. It is low in the same cycle as the strobe.
- Back-to-back frames: a start bit sampled at edge S+1 is accepted, so no idle gap is required. The strobe cycle and the new start-sample cycle coincide without interference.
- parity_err is a registered value, updated together with out_valid and held until the next good frame.
- All outputs are registered, with no combinational path from din.

## Structure
- Shared package/include holds the state encoding localparams: IDLE, DATA, PARITY, STOP, 2-bit binary.
- Frame-length helper constant FRAME_BITS = WIDTH+2+PARITY_EN also lives there, for reuse by the matching serializer and the benches.
- Single module. The WIDTH-bit receive shift register is a natural sub-module: serial_in_shreg, with clock, clear, shift-enable and din, and a parallel output.

## Test plan
- WIDTH=8, PARITY_EN=1, din frame 0,0xA5 LSB-first,parity 0,stop 1 -> out_valid for 1 cycle exactly 10 cycles after the start-sample edge, out_data=0xA5, parity_err=0, frame_err=0.
- Same frame with parity bit 1 -> out_valid=1, out_data=0xA5, parity_err=1.
- Frame 0x3C with stop bit 0 -> frame_err strobe 1 cycle, out_valid never high, out_data keeps its previous value, state IDLE next cycle.
- Frames 0x3C then 0xC3 with no idle gap -> two out_valid strobes exactly 11 cycles apart, data 0x3C then 0xC3, no errors.
- Assert clear low for 1 cycle after 4 data bits of 0x5A -> all outputs 0 immediately. Following frame 0x81 is received correctly; no strobe for the aborted frame.
- WIDTH=4, PARITY_EN=0, fed from the 4-bit shift-register chain with stream 0,1,0,1,1,1 -> out_valid 5 cycles after the start-sample edge, out_data=0xD, parity_err=0.
